// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//   Shared types and helpers for the bit-serial adder controller.
//   - state_t    : controller states IDLE / RUN / DONE
//   - cnt_width  : bit-counter width for a given operand width
// ---------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must reach WIDTH-1.
    // The 1-bit floor keeps the counter a real vector at the smallest width.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_ha_cell.sv
// ---------------------------------------------------------------------------
// ha_cell
//   Gate-level half adder. Two of these, plus an OR, form the single shared
//   full-adder cell of the serial adder.
// Ports
//   s  out 1  sum bit   (a ^ b)
//   c  out 1  carry bit (a & b)
//   a  in  1  input bit
//   b  in  1  input bit
// ---------------------------------------------------------------------------
module ha_cell (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b
);

    xor u_xor (s, a, b);
    and u_and (c, a, b);

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. One full-adder cell (two ha_cell instances
//   plus an OR) is reused for every bit position, LSB first, one bit per clock.
//   An add takes WIDTH RUN cycles followed by a one-cycle DONE.
// Parameters
//   WIDTH  operand/result width, 2..32 (default 8)
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request a new add, honoured only in IDLE or DONE
//   a      in   WIDTH  operand A, captured on an accepted start
//   b      in   WIDTH  operand B, captured on an accepted start
//   sub    in   1      subtract select, only with SERIAL_ADD_SUB_EN
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse when sum/cout become valid
//   sum    out  WIDTH  result, held until the next add completes
//   cout   out  1      carry out of the MSB (with sub: 1 = no borrow)
// Configuration
//   SERIAL_ADD_SUB_EN  adds the sub port; sub=1 computes a - b mod 2^WIDTH
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_sr;
    logic               carry;

    logic               ha0_s;
    logic               ha0_c;
    logic               ha1_s;
    logic               ha1_c;
    logic               carry_next;
    logic               accept;
    logic               last_bit;
    logic [WIDTH-1:0]   sum_sr_next;

    // Shared full adder over the current LSBs and the stored carry.
    ha_cell ha0 (
        .s (ha0_s),
        .c (ha0_c),
        .a (a_sr[0]),
        .b (b_sr[0])
    );

    ha_cell ha1 (
        .s (ha1_s),
        .c (ha1_c),
        .a (ha0_s),
        .b (carry)
    );

    assign carry_next  = ha0_c | ha1_c;
    assign sum_sr_next = {ha1_s, sum_sr[WIDTH-1:1]};
    assign accept      = start && ((state == IDLE) || (state == DONE));
    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));

    // Controller: state, bit counter and the registered busy/done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_bit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // A start here chains straight into the next add.
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: operand shifters, carry, result assembly and output latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            sum_sr <= '0;
`ifdef SERIAL_ADD_SUB_EN
            // Two's-complement subtract: invert b and inject the +1 as carry-in.
            b_sr   <= sub ? ~b : b;
            carry  <= sub;
`else
            b_sr   <= b;
            carry  <= 1'b0;
`endif
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= carry_next;
            sum_sr <= sum_sr_next;
            // The final bit is folded in directly so the result lands with done.
            if (last_bit) begin
                sum  <= sum_sr_next;
                cout <= carry_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Scoreboard bench for serial_add_ctrl (WIDTH=8). Stimulus pushes the
//   hand-computed result of each accepted add; a monitor pops and compares
//   whenever done pulses. Subtract vectors run when SERIAL_ADD_SUB_EN is set.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    exp_t exp_q[$];
    int   checks;
    int   fails;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_done: got sum=%h cout=%b, required no done pulse", sum, cout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (sum !== e.sum || cout !== e.cout) begin
                    fails++;
                    $display("[TB] FAIL result: got sum=%h cout=%b, required sum=%h cout=%b",
                             sum, cout, e.sum, e.cout);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // One-cycle start pulse; the accepted add's hand-computed result is queued.
    task automatic applyStimulus(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                 input logic sub_v, input logic [W-1:0] exp_sum,
                                 input logic exp_cout);
        exp_t e;
        @(posedge clk);
        #1;
        a     = a_v;
        b     = b_v;
        sub   = sub_v;
        start = 1'b1;
        e.sum  = exp_sum;
        e.cout = exp_cout;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles seen on the way.
    task automatic waitDone(input string name, output int busy_cycles);
        bit seen;
        seen        = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL %s: got no done within 40 cycles, required a done pulse", name);
        end
    endtask

    initial begin
        int bc;
        int n;
        int pulses;
        bit seen;

        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        sub    = 1'b0;

        // Reset state
        #23;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_sum",  {24'd0, sum},  32'd0);
        checkOutput("reset_cout", {31'd0, cout}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 0F + 01: eight busy cycles, single-cycle done
        applyStimulus(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        waitDone("done_0f_01", bc);
        checkOutput("busy_cycles", bc, 32'd8);
        checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);

        // FF + 01: wraps with carry, result held while idle
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        waitDone("done_ff_01", bc);
        repeat (5) @(negedge clk);
        checkOutput("held_sum",  {24'd0, sum},  32'h00);
        checkOutput("held_cout", {31'd0, cout}, 32'd1);
        checkOutput("idle_done", {31'd0, done}, 32'd0);

        // 3C + 05 with a start pulse (a=AA) mid-run that must be ignored
        applyStimulus(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a     = 8'hAA;
        b     = 8'hAA;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("done_3c_05", bc);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("ignored_start_pulses", pulses, 32'd0);

        // Reset in the middle of 12 + 34: add discarded, outputs cleared
        applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        checkOutput("midrun_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrun_rst_sum",  {24'd0, sum},  32'd0);
        checkOutput("midrun_rst_cout", {31'd0, cout}, 32'd0);
        seen = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("no_done_after_rst", {31'd0, seen}, 32'd0);
        applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        waitDone("done_after_rst", bc);

        // Back-to-back: start held across DONE, second operands 80 + 80
        @(posedge clk);
        #1;
        a     = 8'h01;
        b     = 8'h02;
        sub   = 1'b0;
        start = 1'b1;
        exp_q.push_back('{sum: 8'h03, cout: 1'b0});
        exp_q.push_back('{sum: 8'h00, cout: 1'b1});
        @(posedge clk);
        #1;
        a = 8'h80;
        b = 8'h80;
        waitDone("b2b_first", bc);
        @(posedge clk);
        #1;
        start = 1'b0;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("b2b_second_seen", {31'd0, seen}, 32'd1);
        checkOutput("b2b_spacing", n, 32'd9);

`ifdef SERIAL_ADD_SUB_EN
        // Subtract: 05 - 07 borrows, 07 - 05 does not
        applyStimulus(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        waitDone("done_sub_05_07", bc);
        applyStimulus(8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
        waitDone("done_sub_07_05", bc);
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
